// File: rtl/dmem_bridge.sv
// Data-memory bridge: stalls the core while one handshaked bus transaction runs.
// Optional bus timeout is compiled in with `define DMEM_BRIDGE_TIMEOUT_EN.
module dmem_bridge #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] data_addr,
    input  logic        should_read_mem,
    input  logic        should_write_mem,
    input  logic [31:0] mem_write_data,
    output logic [31:0] mem_read_data,
    output logic        stall,
    output logic        bus_req_valid,
    input  logic        bus_req_ready,
    output logic        bus_req_write,
    output logic [31:0] bus_req_addr,
    output logic [31:0] bus_req_wdata,
    input  logic        bus_resp_valid,
    input  logic [31:0] bus_resp_rdata,
    output logic        bus_error
);
    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("dmem_bridge: TIMEOUT_CYCLES out of range 1..65535");
    end

    state_t      state;
    logic [31:0] rdata_q;
    logic        mem_req;

    assign mem_req       = should_read_mem | should_write_mem;
    // Combinational so the very first cycle of an access already holds the PC.
    assign stall         = mem_req && (state != DONE);
    assign mem_read_data = rdata_q;

`ifdef DMEM_BRIDGE_TIMEOUT_EN
    logic [15:0] cnt;
    logic        timeout;

    // Fires on the cycle whose increment would make the count reach the limit.
    assign timeout = ({1'b0, cnt} + 17'd1) == 17'(TIMEOUT_CYCLES);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (state == IDLE && mem_req) begin
            cnt <= '0;
        end else if (state == REQ || state == RESP) begin
            cnt <= cnt + 16'd1;
        end
    end
`else
    assign bus_error = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            bus_req_valid <= 1'b0;
            bus_req_write <= 1'b0;
            bus_req_addr  <= '0;
            bus_req_wdata <= '0;
            rdata_q       <= '0;
`ifdef DMEM_BRIDGE_TIMEOUT_EN
            bus_error     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (mem_req) begin
                        state         <= REQ;
                        bus_req_valid <= 1'b1;
                        bus_req_write <= should_write_mem;
                        bus_req_addr  <= data_addr & 32'hFFFF_FFFC;
                        bus_req_wdata <= mem_write_data;
                    end
                end
                REQ: begin
                    if (bus_req_ready) begin
                        state         <= RESP;
                        bus_req_valid <= 1'b0;
                    end
`ifdef DMEM_BRIDGE_TIMEOUT_EN
                    else if (timeout) begin
                        state         <= DONE;
                        bus_req_valid <= 1'b0;
                        rdata_q       <= '0;
                        bus_error     <= 1'b1;
                    end
`endif
                end
                RESP: begin
                    if (bus_resp_valid) begin
                        state <= DONE;
                        if (!bus_req_write) rdata_q <= bus_resp_rdata;
                    end
`ifdef DMEM_BRIDGE_TIMEOUT_EN
                    else if (timeout) begin
                        state     <= DONE;
                        rdata_q   <= '0;
                        bus_error <= 1'b1;
                    end
`endif
                end
                DONE: begin
                    state <= IDLE;
`ifdef DMEM_BRIDGE_TIMEOUT_EN
                    bus_error <= 1'b0;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_bridge.sv
// Randomized transaction-level bench for dmem_bridge: a core/bus model predicts
// stall length, request contents and returned load data per access.
module tb_dmem_bridge;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] data_addr;
    logic        should_read_mem;
    logic        should_write_mem;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;
    logic        stall;
    logic        bus_req_valid;
    logic        bus_req_ready;
    logic        bus_req_write;
    logic [31:0] bus_req_addr;
    logic [31:0] bus_req_wdata;
    logic        bus_resp_valid;
    logic [31:0] bus_resp_rdata;
    logic        bus_error;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_rd = '0;

    dmem_bridge #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .reset(reset),
        .data_addr(data_addr), .should_read_mem(should_read_mem),
        .should_write_mem(should_write_mem), .mem_write_data(mem_write_data),
        .mem_read_data(mem_read_data), .stall(stall),
        .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready),
        .bus_req_write(bus_req_write), .bus_req_addr(bus_req_addr),
        .bus_req_wdata(bus_req_wdata), .bus_resp_valid(bus_resp_valid),
        .bus_resp_rdata(bus_resp_rdata), .bus_error(bus_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One memory instruction; entered at a negedge, returns at the negedge after DONE.
    // The bus side holds ready low rdy_wait cycles and answers resp_wait cycles into RESP.
    task automatic access(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                          input int rdy_wait, input int resp_wait,
                          input logic [31:0] rd, input bit stray);
        int stalls = 0, vcyc = 0, accepts = 0, rw = rdy_wait, sw = resp_wait;
        bit accepted = 0, done = 0;
        should_read_mem  = !wr;
        should_write_mem = wr;
        data_addr        = addr;
        mem_write_data   = wd;
        for (int c = 0; c < 100 && !done; c++) begin
            #1;
            bus_resp_valid = 1'b0;
            bus_resp_rdata = $urandom;
            if (!stall) begin
                done = 1;
                if (!wr) exp_rd = rd;
                chk("rdata_done", mem_read_data, exp_rd);
                chk("valid_done", {31'b0, bus_req_valid}, 32'd0);
                chk("err_done", {31'b0, bus_error}, 32'd0);
            end else begin
                stalls++;
                if (accepted) begin
                    if (sw == 0) begin
                        bus_resp_valid = 1'b1;
                        bus_resp_rdata = rd;
                    end else sw--;
                end else begin
                    bus_resp_valid = stray ? 1'b1 : 1'($urandom);
                end
            end
            if (bus_req_valid) begin
                vcyc++;
                chk("req_addr", bus_req_addr, addr & 32'hFFFF_FFFC);
                chk("req_wdata", bus_req_wdata, wd);
                chk("req_write", {31'b0, bus_req_write}, {31'b0, wr});
                if (rw == 0) begin
                    bus_req_ready = 1'b1;
                    accepts++;
                    accepted = 1;
                end else begin
                    bus_req_ready = 1'b0;
                    rw--;
                end
            end else begin
                bus_req_ready = 1'($urandom);
            end
            @(negedge clk);
        end
        bus_resp_valid = 1'b0;
        bus_req_ready  = 1'b0;
        chk("access_completes", {31'b0, done}, 32'd1);
        chk("stall_cycles", stalls, 3 + rdy_wait + resp_wait);
        chk("valid_cycles", vcyc, rdy_wait + 1);
        chk("accepts", accepts, 1);
    endtask

    task automatic idle_cycle();
        should_read_mem  = 1'b0;
        should_write_mem = 1'b0;
        bus_req_ready    = 1'($urandom);
        bus_resp_valid   = 1'($urandom);
        bus_resp_rdata   = $urandom;
        #1;
        chk("idle_stall", {31'b0, stall}, 32'd0);
        chk("idle_valid", {31'b0, bus_req_valid}, 32'd0);
        chk("idle_rdata", mem_read_data, exp_rd);
        @(negedge clk);
        bus_resp_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        data_addr = '0; mem_write_data = '0;
        should_read_mem = 1'b0; should_write_mem = 1'b0;
        bus_req_ready = 1'b0; bus_resp_valid = 1'b0; bus_resp_rdata = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_valid", {31'b0, bus_req_valid}, 32'd0);
        chk("rst_write", {31'b0, bus_req_write}, 32'd0);
        chk("rst_addr", bus_req_addr, 32'd0);
        chk("rst_wdata", bus_req_wdata, 32'd0);
        chk("rst_rdata", mem_read_data, 32'd0);
        chk("rst_err", {31'b0, bus_error}, 32'd0);
        chk("rst_stall", {31'b0, stall}, 32'd0);
        should_read_mem = 1'b1;
        #1 chk("stall_comb", {31'b0, stall}, 32'd1);
        should_read_mem = 1'b0;
        @(negedge clk);

        // Directed scenarios
        access(1'b0, 32'h0000_1003, 32'h0, 0, 0, 32'hDEAD_BEEF, 1'b0);
        idle_cycle();
        access(1'b1, 32'h0000_0020, 32'h1234_5678, 4, 0, 32'h0BAD_F00D, 1'b0);
        access(1'b0, 32'h0000_0104, 32'h0, 0, 0, 32'h1111_2222, 1'b0);
        access(1'b0, 32'h0000_0108, 32'h0, 1, 1, 32'h3333_4444, 1'b0);
        access(1'b0, 32'h0000_0200, 32'h0, 0, 2, 32'hA5A5_A5A5, 1'b1);

        // Reset while waiting in RESP; later response must be dropped
        should_read_mem = 1'b1; data_addr = 32'h40; bus_req_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_mid_stall", {31'b0, stall}, 32'd1);
        reset = 1'b1; should_read_mem = 1'b0; bus_req_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        exp_rd = '0;
        #1;
        chk("rst_mid_valid", {31'b0, bus_req_valid}, 32'd0);
        chk("rst_mid_rdata", mem_read_data, 32'd0);
        chk("rst_mid_stall0", {31'b0, stall}, 32'd0);
        bus_resp_valid = 1'b1; bus_resp_rdata = 32'hCAFE_CAFE;
        @(negedge clk);
        bus_resp_valid = 1'b0;
        #1 chk("late_resp_ignored", mem_read_data, 32'd0);
        @(negedge clk);

        // Randomized mix of non-memory, load and store instructions
        for (int i = 0; i < 40; i++) begin
            int kind = int'($urandom_range(0, 2));
            if (kind == 0) idle_cycle();
            else access(kind == 2, $urandom, $urandom, int'($urandom_range(0, 2)),
                        int'($urandom_range(0, 2)), $urandom, 1'($urandom));
        end

`ifdef DMEM_BRIDGE_TIMEOUT_EN
        begin
            int vcyc = 0;
            bit done = 0;
            access(1'b0, 32'h300, 32'h0, 0, 0, 32'h7777_7777, 1'b0);
            should_read_mem = 1'b1; data_addr = 32'h0000_0404; bus_req_ready = 1'b0;
            for (int c = 0; c < 40 && !done; c++) begin
                #1;
                bus_resp_valid = 1'b1;
                if (!stall) begin
                    done = 1;
                    chk("to_error", {31'b0, bus_error}, 32'd1);
                    chk("to_rdata", mem_read_data, 32'd0);
                end else if (bus_req_valid) vcyc++;
                @(negedge clk);
            end
            chk("to_completes", {31'b0, done}, 32'd1);
            chk("to_req_cycles", vcyc, 8);
            should_read_mem = 1'b0; bus_resp_rdata = 32'h5555_AAAA;
            #1;
            chk("to_err_pulse", {31'b0, bus_error}, 32'd0);
            chk("to_stall_rel", {31'b0, stall}, 32'd0);
            @(negedge clk);
            bus_resp_valid = 1'b0;
            #1 chk("to_stale_ignored", mem_read_data, 32'd0);
            @(negedge clk);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
